// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
//   Groups the issue-stage, load-return and register-file control signals of
//   the hazard scoreboard into one bundle.
//
//   Issue side (driven by decode/issue and the LSU, "master"):
//     flush, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_is_wb, iss_is_ld,
//     iss_is_st, ld_rsp_valid
//   Control side (driven by the scoreboard, "slave"):
//     fetch_stall, ld_en, st_en, reg_we, reg_waddr, reg_wsel, ld_count, rsp_err
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int RW       = 5,
  parameter int LD_DEPTH = 4
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  logic          flush;
  logic          iss_valid;
  logic [RW-1:0] iss_rs1;
  logic [RW-1:0] iss_rs2;
  logic [RW-1:0] iss_rd;
  logic          iss_is_wb;
  logic          iss_is_ld;
  logic          iss_is_st;
  logic          ld_rsp_valid;

  logic          fetch_stall;
  logic          ld_en;
  logic          st_en;
  logic          reg_we;
  logic [RW-1:0] reg_waddr;
  logic          reg_wsel;
  logic [CW-1:0] ld_count;
  logic          rsp_err;

  modport master (
    output flush, iss_valid, iss_rs1, iss_rs2, iss_rd,
           iss_is_wb, iss_is_ld, iss_is_st, ld_rsp_valid,
    input  fetch_stall, ld_en, st_en, reg_we, reg_waddr, reg_wsel,
           ld_count, rsp_err
  );

  modport slave (
    input  flush, iss_valid, iss_rs1, iss_rs2, iss_rd,
           iss_is_wb, iss_is_ld, iss_is_st, ld_rsp_valid,
    output fetch_stall, ld_en, st_en, reg_we, reg_waddr, reg_wsel,
           ld_count, rsp_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Issue-stage control for a single-issue core with up to LD_DEPTH in-order
//   outstanding loads. Keeps a per-register pending vector and a FIFO of load
//   destination tags; generates the issue stall, LSU enables, and arbitrates
//   the single register-file write port (load return beats ALU writeback).
//
//   Ports:
//     clk    core clock, rising edge
//     reset  asynchronous, active-high; clears pending bits, FIFO, rsp_err
//     sb     hazard_scoreboard_if.slave (issue inputs, control outputs)
//
//   All outputs are combinational from state and the current inputs.
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int LD_DEPTH = 4,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);

  localparam int CW = $clog2(LD_DEPTH) + 1;
  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic [RW-1:0]   fifo_mem [LD_DEPTH];
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   wr_ptr_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            rsp_err_reg;
  logic            rsp_err_next;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [RW-1:0]   head_tag;
  logic [NREG-1:0] eff_pend;
  logic            fifo_empty;
  logic            fifo_full;
  logic            retire;
  logic            raw_hz;
  logic            waw_hz;
  logic            full_hz;
  logic            port_hz;
  logic            stall;
  logic            go;
  logic            push;

  // Pointer increment with explicit wrap so non-trivial depths (and depth 1)
  // never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pending lookup that tolerates indices at or above NREG and treats x0 as
  // never pending.
  function automatic logic reg_pending(input logic [NREG-1:0] vec,
                                       input logic [RW-1:0]   idx);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (idx == RW'(i)) hit = vec[i];
    end
    return hit;
  endfunction

  assign head_tag   = fifo_mem[rd_ptr_reg];
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(LD_DEPTH));
  assign retire     = sb.ld_rsp_valid & ~fifo_empty;

  // Per-register effective-pending and next-pending logic. A load pushed to
  // the same register that is retiring this cycle keeps the bit set: the set
  // term is ORed after the clear.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      assign eff_pend[gi]     = 1'b0;
      assign pending_next[gi] = 1'b0;
    end else begin : g_bit
      logic head_hit;
      logic push_hit;
      assign head_hit         = retire & (head_tag == RW'(gi));
      assign push_hit         = push & (sb.iss_rd == RW'(gi));
      assign eff_pend[gi]     = pending_reg[gi] & ~((BYPASS != 0) & head_hit);
      assign pending_next[gi] = push_hit | (pending_reg[gi] & ~head_hit);
    end
  end

  always_comb begin
    raw_hz  = 1'b0;
    waw_hz  = 1'b0;
    full_hz = 1'b0;
    port_hz = 1'b0;
    if (sb.iss_valid) begin
      raw_hz  = reg_pending(eff_pend, sb.iss_rs1) | reg_pending(eff_pend, sb.iss_rs2);
      waw_hz  = (sb.iss_is_wb | sb.iss_is_ld) & reg_pending(eff_pend, sb.iss_rd);
      // A retire frees a slot in the same cycle, so a full FIFO does not
      // block a load when a response is arriving.
      full_hz = sb.iss_is_ld & fifo_full & ~retire;
      // The returning load owns the single write port this cycle.
      port_hz = sb.iss_is_wb & retire;
    end
  end

  // Flush does not mask the stall; the front end is redirecting anyway.
  assign stall = sb.iss_valid & (raw_hz | waw_hz | full_hz | port_hz);
  assign go    = sb.iss_valid & ~sb.flush & ~stall;
  assign push  = go & sb.iss_is_ld;

  assign sb.fetch_stall = stall;
  assign sb.ld_en       = push;
  assign sb.st_en       = go & sb.iss_is_st;
  assign sb.ld_count    = count_reg;
  assign sb.rsp_err     = rsp_err_reg;

  // Write-port arbitration: load return first, else an accepted ALU op.
  always_comb begin
    sb.reg_we    = 1'b0;
    sb.reg_waddr = '0;
    sb.reg_wsel  = 1'b0;
    if (retire) begin
      sb.reg_we    = (head_tag != '0);
      sb.reg_waddr = head_tag;
      sb.reg_wsel  = 1'b1;
    end else if (go && sb.iss_is_wb && (sb.iss_rd != '0)) begin
      sb.reg_we    = 1'b1;
      sb.reg_waddr = sb.iss_rd;
      sb.reg_wsel  = 1'b0;
    end
  end

  // FIFO pointer/count bookkeeping.
  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    count_next   = count_reg;
    rsp_err_next = rsp_err_reg;
    if (retire) rd_ptr_next = ptr_inc(rd_ptr_reg);
    if (push)   wr_ptr_next = ptr_inc(wr_ptr_reg);
    case ({push, retire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (sb.ld_rsp_valid && fifo_empty) rsp_err_next = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      rsp_err_reg <= rsp_err_next;
    end
  end

  // Tag storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sb.iss_rd;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed-vector bench for hazard_scoreboard (NREG=32, RW=5, LD_DEPTH=4,
//   BYPASS=1). Inputs change 1 ns after the rising edge; combinational outputs
//   are checked 1 ns later, well before the next rising edge.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int RW       = 5;
  localparam int LD_DEPTH = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_scoreboard_if #(.RW(RW), .LD_DEPTH(LD_DEPTH)) sb ();

  hazard_scoreboard #(
    .NREG(32), .RW(RW), .LD_DEPTH(LD_DEPTH), .BYPASS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sb(sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wb, input logic ld,
                       input logic st, input logic rsp, input logic fl);
    sb.iss_valid    = v;
    sb.iss_rs1      = rs1;
    sb.iss_rs2      = rs2;
    sb.iss_rd       = rd;
    sb.iss_is_wb    = wb;
    sb.iss_is_ld    = ld;
    sb.iss_is_st    = st;
    sb.ld_rsp_valid = rsp;
    sb.flush        = fl;
    #1;
  endtask

  task automatic idle(input logic rsp);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, rsp, 1'b0);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle(1'b0);
    step();
    step();
    reset = 1'b0;
    #1;

    // ---- reset state
    chk("rst_count", 32'(sb.ld_count), 0);
    chk("rst_err", 32'(sb.rsp_err), 0);
    chk("rst_we", 32'(sb.reg_we), 0);
    chk("rst_stall", 32'(sb.fetch_stall), 0);
    step();

    // ---- RAW on x5: load, dependent store stalls 3 cycles, issues on response
    drive(1, 0, 0, 5, 0, 1, 0, 0, 0);
    chk("raw_ld_en", 32'(sb.ld_en), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 0, 0, 0, 0, 1, 0, 0);
      chk("raw_stall", 32'(sb.fetch_stall), 1);
      chk("raw_st_blocked", 32'(sb.st_en), 0);
      step();
    end
    drive(1, 5, 0, 0, 0, 0, 1, 1, 0);
    chk("raw_bypass_stall", 32'(sb.fetch_stall), 0);
    chk("raw_bypass_st_en", 32'(sb.st_en), 1);
    chk("raw_ret_we", 32'(sb.reg_we), 1);
    chk("raw_ret_waddr", 32'(sb.reg_waddr), 5);
    chk("raw_ret_wsel", 32'(sb.reg_wsel), 1);
    step();
    idle(0);
    chk("raw_count_after", 32'(sb.ld_count), 0);

    // ---- FIFO full: four loads, fifth stalls, then issues with a response
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 5'(i), 0, 1, 0, 0, 0);
      chk("full_ld_en", 32'(sb.ld_en), 1);
      step();
    end
    idle(0);
    chk("full_count4", 32'(sb.ld_count), 4);
    drive(1, 0, 0, 8, 0, 1, 0, 0, 0);
    chk("full_stall", 32'(sb.fetch_stall), 1);
    chk("full_ld_blocked", 32'(sb.ld_en), 0);
    step();
    drive(1, 0, 0, 8, 0, 1, 0, 1, 0);
    chk("full_rsp_stall", 32'(sb.fetch_stall), 0);
    chk("full_rsp_ld_en", 32'(sb.ld_en), 1);
    chk("full_rsp_waddr", 32'(sb.reg_waddr), 1);
    step();
    idle(0);
    chk("full_count_stays4", 32'(sb.ld_count), 4);
    // drain in issue order: x2, x3, x4, x8
    begin
      logic [4:0] order [4];
      order[0] = 5'd2; order[1] = 5'd3; order[2] = 5'd4; order[3] = 5'd8;
      for (int i = 0; i < 4; i++) begin
        idle(1);
        chk("drain_waddr", 32'(sb.reg_waddr), 32'(order[i]));
        chk("drain_we", 32'(sb.reg_we), 1);
        step();
      end
    end
    idle(0);
    chk("drain_count0", 32'(sb.ld_count), 0);

    // ---- write-port conflict: load x7, ALU x9 in response cycle
    drive(1, 0, 0, 7, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 9, 1, 0, 0, 1, 0);
    chk("port_stall", 32'(sb.fetch_stall), 1);
    chk("port_ld_we", 32'(sb.reg_we), 1);
    chk("port_ld_waddr", 32'(sb.reg_waddr), 7);
    chk("port_ld_wsel", 32'(sb.reg_wsel), 1);
    step();
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0);
    chk("port_alu_stall", 32'(sb.fetch_stall), 0);
    chk("port_alu_we", 32'(sb.reg_we), 1);
    chk("port_alu_waddr", 32'(sb.reg_waddr), 9);
    chk("port_alu_wsel", 32'(sb.reg_wsel), 0);
    step();

    // ---- WAW and same-register push/pop: pending must stay set
    drive(1, 0, 0, 7, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    chk("waw_stall", 32'(sb.fetch_stall), 1);
    step();
    drive(1, 0, 0, 7, 0, 1, 0, 1, 0);
    chk("pushpop_ld_en", 32'(sb.ld_en), 1);
    step();
    drive(1, 7, 0, 0, 0, 0, 1, 0, 0);
    chk("pushpop_still_pending", 32'(sb.fetch_stall), 1);
    chk("pushpop_count", 32'(sb.ld_count), 1);
    step();
    idle(1);
    step();

    // ---- load to x0: never pending, response writes nothing
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_ld_en", 32'(sb.ld_en), 1);
    step();
    drive(1, 0, 0, 10, 1, 0, 0, 0, 0);
    chk("x0_read_stall", 32'(sb.fetch_stall), 0);
    chk("x0_count1", 32'(sb.ld_count), 1);
    step();
    idle(1);
    chk("x0_ret_we", 32'(sb.reg_we), 0);
    step();
    idle(0);
    chk("x0_count0", 32'(sb.ld_count), 0);

    // ---- flush kills an issuing load, older load still retires
    drive(1, 0, 0, 3, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 12, 0, 1, 0, 0, 1);
    chk("flush_ld_en", 32'(sb.ld_en), 0);
    chk("flush_stall", 32'(sb.fetch_stall), 0);
    step();
    idle(0);
    chk("flush_count", 32'(sb.ld_count), 1);
    idle(1);
    chk("flush_ret_we", 32'(sb.reg_we), 1);
    chk("flush_ret_waddr", 32'(sb.reg_waddr), 3);
    step();
    drive(1, 12, 0, 0, 0, 0, 1, 0, 0);
    chk("flush_x12_free", 32'(sb.fetch_stall), 0);
    step();

    // ---- response with empty FIFO, then async reset with loads in flight
    idle(1);
    chk("err_we", 32'(sb.reg_we), 0);
    step();
    idle(0);
    chk("err_set", 32'(sb.rsp_err), 1);
    step();
    chk("err_sticky", 32'(sb.rsp_err), 1);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 2, 0, 1, 0, 0, 0);
    step();
    idle(0);
    chk("pre_rst_count", 32'(sb.ld_count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(sb.ld_count), 0);
    chk("async_rst_err", 32'(sb.rsp_err), 0);
    step();
    reset = 1'b0;
    drive(1, 1, 2, 0, 0, 0, 1, 0, 0);
    chk("rst_pending_clear", 32'(sb.fetch_stall), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-stage control unit for the single-issue core; successor to the single-load hazard logic.
- Tracks up to LD_DEPTH outstanding in-order loads with a per-register pending scoreboard and a destination-tag FIFO.
- Generates stall, register-write and load/store enable signals, and arbitrates the single register-file write port between ALU writeback and load return.
- Sits between decode/issue, the register file and the load/store unit.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- RW, 5, register index width; must satisfy 2^RW >= NREG.
- LD_DEPTH, 4, maximum number of outstanding loads; power of two, at least 1.
- BYPASS, 1, when 1 a register retiring in the current cycle is not treated as pending (write-through register file).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  kills the instruction at issue this cycle.
- iss_valid  in  1  issue stage holds a valid instruction.
- iss_rs1  in  RW  source register 1.
- iss_rs2  in  RW  source register 2.
- iss_rd  in  RW  destination register.
- iss_is_wb  in  1  ALU-type instruction writing rd.
- iss_is_ld  in  1  load instruction.
- iss_is_st  in  1  store instruction.
- ld_rsp_valid  in  1  load data returning this cycle, in issue order.
- fetch_stall  out  1  hold fetch/issue this cycle.
- ld_en  out  1  issue accepted load to LSU.
- st_en  out  1  issue accepted store to LSU.
- reg_we  out  1  register-file write enable.
- reg_waddr  out  RW  register-file write address.
- reg_wsel  out  1  write data select: 1 = load data, 0 = ALU result.
- ld_count  out  $clog2(LD_DEPTH)+1  number of outstanding loads.
- rsp_err  out  1  sticky flag: response received with no outstanding load.

Behaviour:
- State: pending[NREG-1:0] bit vector; tag FIFO of LD_DEPTH entries, each RW bits, with read/write pointers and a count. Reset clears pending, empties the FIFO, and clears rsp_err. All outputs are combinational from state and inputs.
- Retire: a retire occurs when ld_rsp_valid is high and the FIFO is non-empty.
  - The FIFO head is popped; reg_we = (head != 0); reg_waddr = head; reg_wsel = 1.
  - pending[head] is cleared at the clock edge.
  - Retire is never blocked by flush or by a stall.
- Response with an empty FIFO is ignored, and rsp_err is set until reset.
- Effective pending: eff = pending, with bit head cleared when a retire occurs and BYPASS = 1. Register 0 is never pending.
- Hazard conditions, evaluated only when iss_valid is high:
  - raw: eff[rs1] or eff[rs2] is set (index 0 excluded).
  - waw: (iss_is_wb or iss_is_ld) and eff[rd] is set.
  - full: iss_is_ld and the FIFO count equals LD_DEPTH, unless a retire occurs in the same cycle.
  - port: iss_is_wb and a retire occurs in the same cycle (the load owns the write port).
- fetch_stall = iss_valid & (raw | waw | full | port). A flush does not suppress the stall (the front end redirects anyway).
- Accept: go = iss_valid & ~flush & ~fetch_stall.
  - ld_en = go & iss_is_ld.
  - st_en = go & iss_is_st.
  - ALU write, when no retire occurs: reg_we = go & iss_is_wb & (rd != 0); reg_waddr = iss_rd; reg_wsel = 0.
- Accepted load: push iss_rd into the FIFO, including rd = 0 so response order is preserved. Set pending[rd] if rd != 0.
- Simultaneous push and pop:
  - The count is unchanged and both pointers advance.
  - If the push rd equals the retiring head, the set takes priority and pending remains 1.
- Pointers wrap modulo LD_DEPTH.
- ld_count equals the FIFO count. Overflow is impossible by the full rule.
- Flush does not affect in-flight loads; they are older than the flushed instruction and retire normally.
- Idle outputs: reg_we = 0, reg_waddr = 0, reg_wsel = 0.
- Reset asserted mid-operation drops all in-flight tags immediately. The LSU is reset by the same signal.

Test Plan:
- Load x5, then ADD reading x5 the next cycle, response 3 cycles later -> fetch_stall = 1 for 3 cycles. With BYPASS = 1 the ADD issues in the response cycle, with reg_we = 1, reg_waddr = 5, reg_wsel = 1.
- Four loads to x1..x4 with no response, then a fifth load -> first four give ld_en = 1 and ld_count = 4; the fifth stalls. A response in the same cycle lets the fifth issue, and ld_count stays 4.
- Outstanding load x7, ALU op writing x9 issued in the response cycle -> stall for one cycle. The load writes x7 with reg_wsel = 1; the next cycle the ALU writes x9 with reg_wsel = 0.
- Load to x0, then read x0 -> no stall. The response gives reg_we = 0, and ld_count goes 1 -> 0.
- Flush with a valid load and no hazard -> ld_en = 0, nothing pushed. A prior outstanding load still retires with reg_we = 1.
- ld_rsp_valid with an empty FIFO -> rsp_err = 1 and stays set; reg_we = 0. Assert reset with 2 loads outstanding -> ld_count = 0, pending cleared, rsp_err = 0.
